// File: rtl/mac_sequencer.sv
// Sequences a single MAC through an N-element dot product read from two operand RAMs.
// Optional abort support is compiled in when MAC_SEQ_ABORT_EN is defined.
module mac_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RES_W  = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_len,
  output logic              o_busy,
  output logic [RES_W-1:0]  o_result,
  output logic              o_result_valid,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_a,
  input  logic [DATA_W-1:0] i_mem_b,
  output logic [DATA_W-1:0] o_mac_a,
  output logic [DATA_W-1:0] o_mac_b,
  output logic              o_mac_en,
  output logic              o_mac_retro,
  input  logic [RES_W-1:0]  i_mac_out,
  input  logic              i_mac_done
`ifdef MAC_SEQ_ABORT_EN
  ,
  input  logic              i_abort,
  output logic              o_aborted
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        r_state;
  logic              r_busy;
  logic [RES_W-1:0]  r_result;
  logic              r_result_valid;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] r_last;
  logic              r_mac_en;
  logic              r_mac_retro;
  logic [DATA_W-1:0] r_a_hold;
  logic [DATA_W-1:0] r_b_hold;
  logic              r_aborted;

  logic [ADDR_W:0]   w_len_clamped;
  logic [ADDR_W:0]   w_len_m1;
  logic              w_abort;

  assign w_len_clamped = (i_len > LEN_MAX) ? LEN_MAX : i_len;
  assign w_len_m1      = w_len_clamped - {{ADDR_W{1'b0}}, 1'b1};

`ifdef MAC_SEQ_ABORT_EN
  assign w_abort   = i_abort && r_busy;
  assign o_aborted = r_aborted;
`else
  assign w_abort   = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_mem_rd       <= 1'b0;
      r_mem_addr     <= '0;
      r_last         <= '0;
      r_mac_en       <= 1'b0;
      r_mac_retro    <= 1'b0;
      r_a_hold       <= '0;
      r_b_hold       <= '0;
      r_aborted      <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_aborted      <= 1'b0;
      // Issue stage trails the read by one cycle; RAM data lands in that cycle.
      r_mac_en       <= r_mem_rd;
      r_mac_retro    <= r_mem_rd && (r_mem_addr != '0);
      if (r_mac_en) begin
        r_a_hold <= i_mem_a;
        r_b_hold <= i_mem_b;
      end
      if (w_abort) begin
        r_state     <= S_IDLE;
        r_busy      <= 1'b0;
        r_mem_rd    <= 1'b0;
        r_mac_en    <= 1'b0;
        r_mac_retro <= 1'b0;
        r_aborted   <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              if (i_len != '0) begin
                r_state    <= S_FETCH;
                r_busy     <= 1'b1;
                r_mem_rd   <= 1'b1;
                r_mem_addr <= '0;
                r_last     <= w_len_m1[ADDR_W-1:0];
              end else begin
                r_result       <= '0;
                r_result_valid <= 1'b1;
              end
            end
          end
          S_FETCH: begin
            if (r_mem_addr == r_last) begin
              r_mem_rd <= 1'b0;
              r_state  <= S_FLUSH;
            end else begin
              r_mem_addr <= r_mem_addr + 1'b1;
            end
          end
          S_FLUSH: r_state <= S_WAIT;
          S_WAIT: begin
            if (i_mac_done) begin
              r_result       <= i_mac_out;
              r_result_valid <= 1'b1;
              r_busy         <= 1'b0;
              r_state        <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_busy         = r_busy;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_mem_rd       = r_mem_rd;
  assign o_mem_addr     = r_mem_addr;
  assign o_mac_en       = r_mac_en;
  assign o_mac_retro    = r_mac_retro;
  // Operands pass straight from the RAM while issuing, otherwise hold the last issued pair.
  assign o_mac_a        = r_mac_en ? i_mem_a : r_a_hold;
  assign o_mac_b        = r_mac_en ? i_mem_b : r_b_hold;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: behavioural RAM + MAC models, dot-product reference by summation.
module tb_mac_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [8:0]  len;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_a;
  logic [15:0] mem_b;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic        mac_en;
  logic        mac_retro;
  logic [31:0] mac_out;
  logic        mac_done;
  logic        abort;
  logic        aborted;

  logic [15:0] ram_a [256];
  logic [15:0] ram_b [256];

  int checks = 0;
  int errors = 0;

  mac_sequencer dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_len          (len),
    .o_busy         (busy),
    .o_result       (result),
    .o_result_valid (result_valid),
    .o_mem_rd       (mem_rd),
    .o_mem_addr     (mem_addr),
    .i_mem_a        (mem_a),
    .i_mem_b        (mem_b),
    .o_mac_a        (mac_a),
    .o_mac_b        (mac_b),
    .o_mac_en       (mac_en),
    .o_mac_retro    (mac_retro),
    .i_mac_out      (mac_out),
    .i_mac_done     (mac_done)
`ifdef MAC_SEQ_ABORT_EN
    ,
    .i_abort        (abort),
    .o_aborted      (aborted)
`endif
  );

`ifndef MAC_SEQ_ABORT_EN
  assign aborted = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous operand RAMs.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_a <= ram_a[mem_addr];
      mem_b <= ram_b[mem_addr];
    end
  end

  // MAC processor model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_out  <= 32'd0;
      mac_done <= 1'b0;
    end else begin
      mac_done <= mac_en;
      if (mac_en) mac_out <= (mac_retro ? mac_out : 32'd0) + mac_a * mac_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_dot(input int n);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < n; i++) s = s + ram_a[i] * ram_b[i];
    return s;
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      ram_a[i] = 16'($urandom);
      ram_b[i] = 16'($urandom);
    end
  endtask

  // Issues one command and follows it to result_valid; returns at the negedge of that cycle.
  task automatic run_cmd(input string tag, input int n, input bit b2b, input bit poke);
    int          eff;
    int          lat;
    int          cyc;
    int          rd_cnt;
    int          en_cnt;
    bit          got;
    bit          addr_ok;
    bit          retro_ok;
    bit          ab_ok;
    bit          busy_ok;
    logic [31:0] exp;
    eff      = (n > 256) ? 256 : n;
    lat      = (eff == 0) ? 1 : eff + 3;
    exp      = ref_dot(eff);
    rd_cnt   = 0;
    en_cnt   = 0;
    got      = 1'b0;
    addr_ok  = 1'b1;
    retro_ok = 1'b1;
    ab_ok    = 1'b1;
    busy_ok  = 1'b1;
    if (!b2b) @(negedge clk);
    start = 1'b1;
    len   = 9'(n);
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!got && cyc < 700) begin
      if (mem_rd) begin
        if (mem_addr !== 8'(rd_cnt)) addr_ok = 1'b0;
        rd_cnt++;
      end
      if (mac_en) begin
        if (mac_retro !== (en_cnt != 0)) retro_ok = 1'b0;
        if (en_cnt > 255 || mac_a !== ram_a[en_cnt] || mac_b !== ram_b[en_cnt]) ab_ok = 1'b0;
        en_cnt++;
      end
      if (result_valid) begin
        got = 1'b1;
      end else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (poke && cyc == 2) begin
          start = 1'b1;
          len   = 9'd1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, "_valid_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_result"}, result, exp);
    check({tag, "_reads"}, 32'(rd_cnt), 32'(eff));
    check({tag, "_enables"}, 32'(en_cnt), 32'(eff));
    check({tag, "_addr_seq"}, 32'(addr_ok), 32'd1);
    check({tag, "_retro_seq"}, 32'(retro_ok), 32'd1);
    check({tag, "_operands"}, 32'(ab_ok), 32'd1);
    check({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rv"}, 32'(result_valid), 32'd0);
    check({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mac_en"}, 32'(mac_en), 32'd0);
    check({tag, "_retro"}, 32'(mac_retro), 32'd0);
    check({tag, "_mac_a"}, 32'(mac_a), 32'd0);
    check({tag, "_mac_b"}, 32'(mac_b), 32'd0);
    check({tag, "_result"}, result, 32'd0);
  endtask

  initial begin
    logic [31:0] saved;
    bit          rv_seen;
    rst_n = 1'b0;
    start = 1'b0;
    len   = 9'd0;
    abort = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram_a[i] = 16'd0;
      ram_b[i] = 16'd0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    check("reset_aborted", 32'(aborted), 32'd0);

    // Directed len=4 case.
    for (int i = 0; i < 4; i++) begin
      ram_a[i] = 16'(i + 1);
      ram_b[i] = 16'(i + 5);
    end
    run_cmd("len4", 4, 1'b0, 1'b0);
    check("len4_const", result, 32'd70);
    check("len4_hold_a", 32'(mac_a), 32'd4);
    check("len4_hold_b", 32'(mac_b), 32'd8);
    @(negedge clk);
    check("len4_rv_pulse", 32'(result_valid), 32'd0);
    check("len4_result_held", result, 32'd70);

    run_cmd("len0", 0, 1'b0, 1'b0);
    check("len0_const", result, 32'd0);

    // Back-to-back, with a start poked while busy.
    fill_random(5);
    run_cmd("b2b_first", 5, 1'b0, 1'b0);
    ram_a[0] = 16'd2;
    ram_a[1] = 16'd3;
    ram_b[0] = 16'd4;
    ram_b[1] = 16'd5;
    run_cmd("b2b_second", 2, 1'b1, 1'b1);
    check("b2b_const", result, 32'd23);
    @(negedge clk);
    check("poke_ignored_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 256; i++) begin
      ram_a[i] = 16'hFFFF;
      ram_b[i] = 16'hFFFF;
    end
    run_cmd("len256", 256, 1'b0, 1'b0);
    check("len256_const", result, 32'hFE000100);

    fill_random(256);
    run_cmd("clamp511", 511, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      int n;
      n = int'($urandom_range(1, 24));
      fill_random(n);
      run_cmd($sformatf("rand%0d", k), n, 1'b0, 1'b0);
    end

    // Reset in the middle of a len=8 command.
    fill_random(8);
    @(negedge clk);
    start = 1'b1;
    len   = 9'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    ram_a[0] = 16'd3;
    ram_b[0] = 16'd9;
    run_cmd("after_reset", 1, 1'b0, 1'b0);
    check("after_reset_const", result, 32'd27);

`ifdef MAC_SEQ_ABORT_EN
    saved = result;
    fill_random(8);
    @(negedge clk);
    start = 1'b1;
    len   = 9'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_pulse", 32'(aborted), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_rd", 32'(mem_rd), 32'd0);
    check("abort_mac_en", 32'(mac_en), 32'd0);
    rv_seen = 1'b0;
    @(negedge clk);
    check("abort_one_cycle", 32'(aborted), 32'd0);
    for (int i = 0; i < 12; i++) begin
      if (result_valid) rv_seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_rv", 32'(rv_seen), 32'd0);
    check("abort_result_kept", result, saved);
`else
    saved   = 32'd0;
    rv_seen = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
